// File: rtl/shift_frame_controller_pkg.sv
// Shared definitions for shift_frame_controller: FSM state encoding and the
// default frame length.
package shift_frame_controller_pkg;

    localparam int unsigned DefaultDepth = 8;

    // Encoding is fixed; PARITY only exists in the parity-enabled build.
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StClear  = 3'd1,
        StShift  = 3'd2,
        StDone   = 3'd3,
        StParity = 3'd4
    } state_e;

endpackage

// File: rtl/left_shift_register_base.sv
// Left shift register, MSB-first capture: new bits enter at the LSB.
// Asynchronous active-low reset plus a synchronous clear, both to zero.
module left_shift_register_base #(
    parameter int unsigned DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_d,
    output logic [DEPTH-1:0] o_q
);

    logic [DEPTH-1:0] r_q;

    // Shift state: clear has priority over a shift in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= {r_q[DEPTH-2:0], i_d};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/shift_frame_controller.sv
// Serial-to-parallel frame capture controller.
// IDLE -> CLEAR -> SHIFT -> DONE, with abort returning to IDLE from anywhere.
// Define SHIFT_FRAME_CTRL_PARITY_EN to add a PARITY state after SHIFT that
// takes one even-parity bit and reports parity_err while in DONE.
module shift_frame_controller
    import shift_frame_controller_pkg::*;
#(
    parameter int unsigned DEPTH = DefaultDepth
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic             serial_in,
    input  logic             serial_valid,
    output logic [DEPTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             busy
`ifdef SHIFT_FRAME_CTRL_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    state_e           r_state;
    logic [CntW-1:0]  r_count;
    logic             r_word_valid;
    logic             r_busy;
    logic             w_sr_en;
    logic             w_sr_clr;
    logic [DEPTH-1:0] w_sr_q;
    logic             w_last_bit;
`ifdef SHIFT_FRAME_CTRL_PARITY_EN
    logic             r_parity_err;
`endif

    // Shift only on accepted data bits; the register is cleared by CLEAR or reset.
    assign w_sr_en    = (r_state == StShift) && serial_valid;
    assign w_sr_clr   = (r_state == StClear);
    assign w_last_bit = (r_count == CntW'(DEPTH - 1));

    left_shift_register_base #(
        .DEPTH (DEPTH)
    ) u_shreg (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_clr   (w_sr_clr),
        .i_en    (w_sr_en),
        .i_d     (serial_in),
        .o_q     (w_sr_q)
    );

    // Frame FSM with registered word_valid/busy; abort overrides every state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= StIdle;
            r_count      <= '0;
            r_word_valid <= 1'b0;
            r_busy       <= 1'b0;
`ifdef SHIFT_FRAME_CTRL_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else if (abort) begin
            r_state      <= StIdle;
            r_count      <= '0;
            r_word_valid <= 1'b0;
            r_busy       <= 1'b0;
`ifdef SHIFT_FRAME_CTRL_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_state <= StClear;
                        r_busy  <= 1'b1;
                    end
                end
                StClear: begin
                    r_count <= '0;
                    r_state <= StShift;
                end
                StShift: begin
                    if (serial_valid) begin
                        r_count <= r_count + CntW'(1);
                        if (w_last_bit) begin
`ifdef SHIFT_FRAME_CTRL_PARITY_EN
                            r_state      <= StParity;
`else
                            r_state      <= StDone;
                            r_word_valid <= 1'b1;
`endif
                        end
                    end
                end
`ifdef SHIFT_FRAME_CTRL_PARITY_EN
                StParity: begin
                    // Parity bit is checked against the frame, never shifted in.
                    if (serial_valid) begin
                        r_state      <= StDone;
                        r_word_valid <= 1'b1;
                        r_parity_err <= (^w_sr_q) ^ serial_in;
                    end
                end
`endif
                StDone: begin
                    if (word_ready) begin
                        r_state      <= StIdle;
                        r_count      <= '0;
                        r_word_valid <= 1'b0;
                        r_busy       <= 1'b0;
`ifdef SHIFT_FRAME_CTRL_PARITY_EN
                        r_parity_err <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_state      <= StIdle;
                    r_count      <= '0;
                    r_word_valid <= 1'b0;
                    r_busy       <= 1'b0;
`ifdef SHIFT_FRAME_CTRL_PARITY_EN
                    r_parity_err <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign word_out   = w_sr_q;
    assign word_valid = r_word_valid;
    assign busy       = r_busy;
`ifdef SHIFT_FRAME_CTRL_PARITY_EN
    assign parity_err = r_parity_err;
`endif

endmodule

// File: doc/shift_frame_controller.md
SHIFT_FRAME_CONTROLLER -- requirements
Module: shift_frame_controller

Interface
REQ-001 SHALL have parameter DEPTH, default 8, giving the frame length in bits and the width of word_out; legal range is 2..32.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin capturing a frame.
REQ-005 SHALL have port abort, input, 1 bit: discard the current frame and return to IDLE.
REQ-006 SHALL have port serial_in, input, 1 bit: frame data bit, MSB first.
REQ-007 SHALL have port serial_valid, input, 1 bit: serial_in is valid in this cycle.
REQ-008 SHALL have port word_out, output, DEPTH bits: the captured frame.
REQ-009 SHALL have port word_valid, output, 1 bit: word_out holds a complete frame.
REQ-010 SHALL have port word_ready, input, 1 bit: the consumer accepts word_out.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-012 SHALL implement a four-state FSM: IDLE, CLEAR, SHIFT, DONE.
REQ-013 IDLE: start=1 -> CLEAR.
REQ-014 CLEAR lasts exactly 1 cycle, clears the shift register, sets the bit count to 0, then -> SHIFT.
REQ-015 SHIFT: each cycle with serial_valid=1 shifts serial_in into the LSB (left shift) and increments the count; serial_valid=0 holds all state.
REQ-016 SHIFT: the accepted bit that makes the count reach DEPTH -> DONE on the next edge.
REQ-017 DONE: word_valid=1 and word_out is held stable; word_valid AND word_ready -> IDLE, and word_valid drops on the next cycle.
REQ-018 Latency: word_valid rises on the edge that samples the DEPTH-th valid bit.
REQ-019 start in any state other than IDLE SHALL be ignored; serial_valid outside SHIFT SHALL be ignored.
REQ-020 abort=1 in any state -> IDLE on the next edge; word_valid=0 and the count is cleared; the shift register contents are don't-care.
REQ-021 Simultaneous abort and start in IDLE: abort wins, the FSM stays in IDLE.
REQ-022 The bit count SHALL be $clog2(DEPTH+1) bits wide and SHALL never exceed DEPTH.
REQ-023 word_out SHALL equal the shift register contents at all times; it is guaranteed meaningful only while word_valid=1.

Reset
REQ-024 reset_n=0 SHALL asynchronously force: state IDLE, count 0, shift register all zeros, word_out=0, word_valid=0, busy=0.
REQ-025 Reset asserted mid-frame SHALL discard the frame; after release the block waits in IDLE for start.

Configuration
REQ-026 Macro SHIFT_FRAME_CTRL_PARITY_EN, when defined, SHALL add state PARITY between SHIFT and DONE and an output parity_err (1 bit).
REQ-027 With the macro defined: after DEPTH data bits, the next valid serial_in is the even-parity bit and is not shifted into word_out; in DONE, parity_err = (XOR of word_out) XOR (parity bit).
REQ-028 parity_err SHALL be 0 outside DONE and SHALL reset to 0.
REQ-029 Without the macro: no PARITY state and no parity_err port; DONE follows SHIFT directly.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding (IDLE=0, CLEAR=1, SHIFT=2, DONE=3, PARITY=4) and the default DEPTH constant.
REQ-031 The shift register SHALL be a single sub-module, left_shift_register_base, instantiated with DEPTH.
REQ-032 The controller SHALL drive the sub-module's enable from (state==SHIFT AND serial_valid) and its reset from (CLEAR OR NOT reset_n).

Verification
REQ-033 Frame, DEPTH=8: start, then bits 1,1,0,1,0,1,1,0 on consecutive cycles, word_ready=1 -> word_out=8'hD6, word_valid high exactly 1 cycle, busy falls the following cycle.
REQ-034 Gaps: the same frame with serial_valid=0 on every other cycle -> word_out=8'hD6, and word_valid rises 1 cycle after the 8th valid bit.
REQ-035 Backpressure: word_ready=0 for 5 cycles in DONE -> word_valid and word_out=8'hD6 stay stable; a new start is ignored; word_ready=1 -> IDLE.
REQ-036 Abort: abort after 4 bits -> IDLE next cycle, word_valid=0; a new frame 8'hA5 then captures correctly.
REQ-037 Reset mid-SHIFT: reset_n=0 after 3 bits -> all outputs 0 immediately, without waiting for a clock edge.
REQ-038 Parity build: frame 8'hD6 followed by parity bit 1 -> parity_err=0; followed by parity bit 0 -> parity_err=1.
